// File: rtl/adc_axim_buf_writer.sv
// rtl/adc_axim_buf_writer.sv - AXI4 write master draining an FWFT sample FIFO into ping-pong DDR buffers
module adc_axim_buf_writer #(
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                    axim_clk,
  input  logic                    axim_rstn,
  input  logic                    go,
  input  logic                    int_clr,
  input  logic [31:0]             data_len,
  input  logic [31:0]             wr_addr_0,
  input  logic [31:0]             wr_addr_1,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  input  logic [CNT_WIDTH-1:0]    fifo_rd_count,
  input  logic                    fifo_ovf,
  output logic                    fifo_rd_en,
  output logic [31:0]             m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic                    done,
  output logic                    int_out,
  output logic                    fifo_overflow,
  output logic [3:0]              wr_buf_index,
  output logic [31:0]             write_count
);
  localparam int BB = BURST_LEN * DATA_WIDTH / 8;
  localparam int BB_LOG2 = $clog2(BB);
  localparam logic [31:0] BB32 = 32'(BB);
  localparam logic [31:0] BASE_MASK = ~((32'd1 << BB_LOG2) - 32'd1);
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] BL_CNT = CNT_WIDTH'(BURST_LEN);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_AW, S_W, S_B, S_NEXT} state_t;

  state_t      state_q, state_d;
  logic        go_dly_q, go_dly_d, int_clr_dly_q, int_clr_dly_d;
  logic [31:0] nbursts_q, nbursts_d, burst_idx_q, burst_idx_d, base_q, base_d;
  logic [31:0] awaddr_q, awaddr_d, write_count_q, write_count_d;
  logic [7:0]  beat_q, beat_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic        bready_q, bready_d, done_q, done_d, int_out_q, int_out_d;
  logic        fifo_overflow_q, fifo_overflow_d, cur_buf_q, cur_buf_d;
  logic [3:0]  wr_buf_index_q, wr_buf_index_d;
  logic        go_rise, int_clr_rise;
  logic        unused_bresp;

  // Response code is deliberately not inspected: every acknowledged burst counts.
  assign unused_bresp = ^m_axi_bresp;

  always_comb begin
    state_d         = state_q;
    go_dly_d        = go;
    int_clr_dly_d   = int_clr;
    nbursts_d       = nbursts_q;
    burst_idx_d     = burst_idx_q;
    base_d          = base_q;
    awaddr_d        = awaddr_q;
    write_count_d   = write_count_q;
    beat_d          = beat_q;
    awvalid_d       = awvalid_q;
    wvalid_d        = wvalid_q;
    wlast_d         = wlast_q;
    bready_d        = bready_q;
    done_d          = done_q;
    int_out_d       = int_out_q;
    fifo_overflow_d = fifo_overflow_q;
    cur_buf_d       = cur_buf_q;
    wr_buf_index_d  = wr_buf_index_q;
    go_rise         = go & ~go_dly_q;
    int_clr_rise    = int_clr & ~int_clr_dly_q;

    // Clear first so that a completion in the same cycle sets it back.
    if (int_clr_rise) int_out_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go_rise) begin
          done_d          = 1'b0;
          fifo_overflow_d = 1'b0;
          write_count_d   = '0;
          if (data_len >= BB32) begin
            nbursts_d   = data_len / BB32;
            base_d      = (cur_buf_q ? wr_addr_1 : wr_addr_0) & BASE_MASK;
            burst_idx_d = '0;
            state_d     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (fifo_rd_count >= BL_CNT) begin
          awaddr_d  = base_q + burst_idx_q * BB32;
          awvalid_d = 1'b1;
          state_d   = S_AW;
        end
      end
      S_AW: begin
        if (m_axi_awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          beat_d    = '0;
          wlast_d   = (LAST_BEAT == 8'd0);
          state_d   = S_W;
        end
      end
      S_W: begin
        if (m_axi_wready) begin
          if (beat_q == LAST_BEAT) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            state_d  = S_B;
          end else begin
            beat_d  = beat_q + 8'd1;
            wlast_d = ((beat_q + 8'd1) == LAST_BEAT);
          end
        end
      end
      S_B: begin
        if (m_axi_bvalid) begin
          bready_d      = 1'b0;
          write_count_d = write_count_q + BB32;
          burst_idx_d   = burst_idx_q + 32'd1;
          state_d       = S_NEXT;
        end
      end
      S_NEXT: begin
        if (burst_idx_q < nbursts_q) begin
          state_d = go ? S_WAIT : S_IDLE;
        end else begin
          int_out_d      = 1'b1;
          wr_buf_index_d = wr_buf_index_q + 4'd1;
          cur_buf_d      = ~cur_buf_q;
          if (go && (data_len >= BB32)) begin
            nbursts_d     = data_len / BB32;
            base_d        = (cur_buf_q ? wr_addr_0 : wr_addr_1) & BASE_MASK;
            burst_idx_d   = '0;
            write_count_d = '0;
            state_d       = S_WAIT;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fifo_ovf) fifo_overflow_d = 1'b1;
  end

  always_ff @(posedge axim_clk or negedge axim_rstn) begin
    if (!axim_rstn) begin
      state_q         <= S_IDLE;
      go_dly_q        <= 1'b0;
      int_clr_dly_q   <= 1'b0;
      nbursts_q       <= '0;
      burst_idx_q     <= '0;
      base_q          <= '0;
      awaddr_q        <= '0;
      write_count_q   <= '0;
      beat_q          <= '0;
      awvalid_q       <= 1'b0;
      wvalid_q        <= 1'b0;
      wlast_q         <= 1'b0;
      bready_q        <= 1'b0;
      done_q          <= 1'b0;
      int_out_q       <= 1'b0;
      fifo_overflow_q <= 1'b0;
      cur_buf_q       <= 1'b0;
      wr_buf_index_q  <= '0;
    end else begin
      state_q         <= state_d;
      go_dly_q        <= go_dly_d;
      int_clr_dly_q   <= int_clr_dly_d;
      nbursts_q       <= nbursts_d;
      burst_idx_q     <= burst_idx_d;
      base_q          <= base_d;
      awaddr_q        <= awaddr_d;
      write_count_q   <= write_count_d;
      beat_q          <= beat_d;
      awvalid_q       <= awvalid_d;
      wvalid_q        <= wvalid_d;
      wlast_q         <= wlast_d;
      bready_q        <= bready_d;
      done_q          <= done_d;
      int_out_q       <= int_out_d;
      fifo_overflow_q <= fifo_overflow_d;
      cur_buf_q       <= cur_buf_d;
      wr_buf_index_q  <= wr_buf_index_d;
    end
  end

  assign fifo_rd_en    = wvalid_q & m_axi_wready;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = LAST_BEAT;
  assign m_axi_awsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = fifo_rd_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign done          = done_q;
  assign int_out       = int_out_q;
  assign fifo_overflow = fifo_overflow_q;
  assign wr_buf_index  = wr_buf_index_q;
  assign write_count   = write_count_q;
endmodule

// File: tb/tb_adc_axim_buf_writer.sv
// tb/tb_adc_axim_buf_writer.sv - scoreboard bench for adc_axim_buf_writer
module tb_adc_axim_buf_writer;
  localparam int BL = 16;

  logic        axim_clk = 1'b0;
  logic        axim_rstn = 1'b0;
  logic        go = 1'b0, int_clr = 1'b0, fifo_ovf = 1'b0;
  logic [31:0] data_len = '0, wr_addr_0 = '0, wr_addr_1 = '0;
  logic [63:0] fifo_rd_data = '0;
  logic [9:0]  fifo_rd_count = '0;
  logic        fifo_rd_en;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready = 1'b0;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready = 1'b1;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0, m_axi_bready;
  logic        done, int_out, fifo_overflow;
  logic [3:0]  wr_buf_index;
  logic [31:0] write_count;

  adc_axim_buf_writer #(.DATA_WIDTH(64), .BURST_LEN(BL), .CNT_WIDTH(10)) dut (
    .axim_clk(axim_clk), .axim_rstn(axim_rstn), .go(go), .int_clr(int_clr),
    .data_len(data_len), .wr_addr_0(wr_addr_0), .wr_addr_1(wr_addr_1),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_count(fifo_rd_count), .fifo_ovf(fifo_ovf),
    .fifo_rd_en(fifo_rd_en), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .done(done), .int_out(int_out), .fifo_overflow(fifo_overflow),
    .wr_buf_index(wr_buf_index), .write_count(write_count)
  );

  always #5 axim_clk = ~axim_clk;

  int n_cmp = 0, n_err = 0;
  logic [63:0] fq[$];
  logic [63:0] exp_wd[$];
  logic [31:0] exp_aw[$];
  int cnt_override = -1;
  int aw_delay = 0, aw_wait = 0;
  bit w_toggle = 1'b0;
  int aw_cnt = 0, b_cnt = 0, w_beat = 0, pops = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fifo_refresh();
    int n;
    n = fq.size();
    fifo_rd_data = (n > 0) ? fq[0] : 64'd0;
    if (cnt_override >= 0) n = cnt_override;
    fifo_rd_count = (n > 1023) ? 10'd1023 : 10'(n);
  endtask

  task automatic push_words(input int n);
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      fq.push_back(w);
      exp_wd.push_back(w);
    end
    fifo_refresh();
  endtask

  // Expected AW addresses of one run: count bursts from base in BB=128 steps.
  task automatic expect_bursts(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_aw.push_back(base + 32'(i * 128));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge axim_clk);
    #1;
  endtask

  // which: 0 = AW handshakes, 1 = B handshakes, 2 = beat within burst
  task automatic wait_cnt(input string tag, input int which, input int target);
    int n;
    int v;
    n = 0;
    v = -1;
    while (n < 3000) begin
      @(negedge axim_clk);
      #1;
      v = (which == 0) ? aw_cnt : ((which == 1) ? b_cnt : w_beat);
      if (v >= target) break;
      n++;
    end
    if (n >= 3000) chk({tag, "_timeout"}, 64'(v), 64'(target));
  endtask

  task automatic do_reset();
    axim_rstn = 1'b0;
    go = 1'b0;
    int_clr = 1'b0;
    fifo_ovf = 1'b0;
    #1;
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_done", done, 0);
    chk("rst_int_out", int_out, 0);
    chk("rst_ovf", fifo_overflow, 0);
    chk("rst_buf_idx", wr_buf_index, 0);
    chk("rst_wcount", write_count, 0);
    exp_aw.delete();
    cyc(2);
    axim_rstn = 1'b1;
    aw_cnt = 0;
    b_cnt = 0;
  endtask

  // AXI slave, FIFO model and output monitor
  initial begin
    bit aw_hs, w_hs, b_hs;
    forever begin
      @(negedge axim_clk);
      aw_hs = 1'b0; w_hs = 1'b0; b_hs = 1'b0;
      if (!axim_rstn) begin
        w_beat = 0;
        pops = 0;
      end else begin
        if (m_axi_awvalid) begin
          if (exp_aw.size() == 0) chk("aw_unexpected", m_axi_awvalid, 0);
          else begin
            chk("awaddr", m_axi_awaddr, exp_aw[0]);
            if (m_axi_awready) begin
              chk("awlen", m_axi_awlen, BL - 1);
              chk("awsize", m_axi_awsize, 3);
              chk("awburst", m_axi_awburst, 1);
              void'(exp_aw.pop_front());
              aw_cnt++;
              aw_hs = 1'b1;
            end
          end
        end
        chk("rd_en", fifo_rd_en, m_axi_wvalid & m_axi_wready);
        if (fifo_rd_en) pops++;
        if (m_axi_wvalid && m_axi_wready) begin
          w_hs = 1'b1;
          if (exp_wd.size() == 0) chk("w_unexpected", m_axi_wvalid, 0);
          else begin
            chk("wdata", m_axi_wdata, exp_wd.pop_front());
            chk("wstrb", m_axi_wstrb, 8'hff);
          end
          chk("wlast", m_axi_wlast, (w_beat == BL - 1));
          if (w_beat == BL - 1) begin
            chk("pops_per_burst", pops, BL);
            pops = 0;
            w_beat = 0;
          end else w_beat++;
        end
        if (m_axi_bvalid && m_axi_bready) begin
          b_hs = 1'b1;
          b_cnt++;
        end
      end
      @(posedge axim_clk);
      #1;
      if (!axim_rstn) begin
        m_axi_awready = 1'b0;
        m_axi_bvalid = 1'b0;
        aw_wait = 0;
        m_axi_wready = ~w_toggle;
      end else begin
        if (w_hs && fq.size() > 0) begin
          void'(fq.pop_front());
          fifo_refresh();
        end
        if (aw_hs) begin
          m_axi_awready = 1'b0;
          aw_wait = 0;
        end else if (m_axi_awvalid) begin
          if (aw_wait >= aw_delay) m_axi_awready = 1'b1;
          else aw_wait++;
        end
        m_axi_wready = w_toggle ? ~m_axi_wready : 1'b1;
        if (b_hs) m_axi_bvalid = 1'b0;
        else if (m_axi_bready) m_axi_bvalid = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fifo_refresh();
    // Single buffer of 4 bursts
    do_reset();
    wr_addr_0 = 32'h1000_0000;
    wr_addr_1 = 32'h2000_0000;
    data_len = 512;
    push_words(64);
    expect_bursts(32'h1000_0000, 4);
    cyc(1);
    go = 1'b1;
    wait_cnt("t1_aw", 0, 4);
    cyc(1);
    go = 1'b0;
    wait_cnt("t1_b", 1, 4);
    cyc(3);
    @(negedge axim_clk);
    chk("t1_wcount", write_count, 512);
    chk("t1_done", done, 1);
    chk("t1_int", int_out, 1);
    chk("t1_idx", wr_buf_index, 1);
    chk("t1_aw_left", exp_aw.size(), 0);

    // Ping-pong across three buffers with go held
    do_reset();
    data_len = 256;
    push_words(96);
    expect_bursts(32'h1000_0000, 2);
    expect_bursts(32'h2000_0000, 2);
    expect_bursts(32'h1000_0000, 2);
    cyc(1);
    go = 1'b1;
    wait_cnt("t2_b2", 1, 2);
    @(posedge axim_clk);
    @(posedge axim_clk);
    @(negedge axim_clk);
    chk("t2_idx1", wr_buf_index, 1);
    chk("t2_wc_clr1", write_count, 0);
    wait_cnt("t2_b4", 1, 4);
    @(posedge axim_clk);
    @(posedge axim_clk);
    @(negedge axim_clk);
    chk("t2_idx2", wr_buf_index, 2);
    chk("t2_wc_clr2", write_count, 0);
    wait_cnt("t2_aw6", 0, 6);
    cyc(1);
    go = 1'b0;
    wait_cnt("t2_b6", 1, 6);
    cyc(3);
    chk("t2_idx3", wr_buf_index, 3);
    chk("t2_done", done, 1);
    chk("t2_wcount", write_count, 256);

    // Backpressure: FIFO short of a burst, slow awready, toggling wready, error bresp
    aw_cnt = 0; b_cnt = 0;
    aw_delay = 5;
    w_toggle = 1'b1;
    m_axi_bresp = 2'b10;
    cnt_override = 15;
    push_words(32);
    expect_bursts(32'h2000_0000, 2);
    go = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge axim_clk);
      chk("t3_no_aw", m_axi_awvalid, 0);
    end
    cyc(1);
    cnt_override = -1;
    fifo_refresh();
    wait_cnt("t3_aw", 0, 2);
    cyc(1);
    go = 1'b0;
    wait_cnt("t3_b", 1, 2);
    cyc(3);
    chk("t3_wcount", write_count, 256);
    chk("t3_done", done, 1);
    chk("t3_idx", wr_buf_index, 4);
    aw_delay = 0;
    w_toggle = 1'b0;
    m_axi_bresp = 2'b00;

    // Remainder dropped and unaligned base
    aw_cnt = 0; b_cnt = 0;
    data_len = 300;
    wr_addr_0 = 32'h1000_0044;
    push_words(32);
    expect_bursts(32'h1000_0000, 2);
    go = 1'b1;
    wait_cnt("t4_aw", 0, 2);
    cyc(1);
    go = 1'b0;
    wait_cnt("t4_b", 1, 2);
    cyc(3);
    chk("t4_wcount", write_count, 256);
    chk("t4_done", done, 1);
    chk("t4_idx", wr_buf_index, 5);

    // Too short for one burst: stays idle
    aw_cnt = 0;
    data_len = 100;
    go = 1'b1;
    cyc(1);
    go = 1'b0;
    cyc(30);
    chk("t4_short_aw", aw_cnt, 0);
    chk("t4_short_done", done, 0);
    chk("t4_short_wc", write_count, 0);

    // Interrupt clear, and clear colliding with completion
    int_clr = 1'b1;
    cyc(1);
    int_clr = 1'b0;
    @(negedge axim_clk);
    chk("t5_int_clr", int_out, 0);
    aw_cnt = 0; b_cnt = 0;
    data_len = 128;
    push_words(16);
    expect_bursts(32'h2000_0000, 1);
    cyc(1);
    go = 1'b1;
    wait_cnt("t5_aw", 0, 1);
    cyc(1);
    go = 1'b0;
    wait_cnt("t5_b", 1, 1);
    cyc(1);
    int_clr = 1'b1;
    @(posedge axim_clk);
    @(negedge axim_clk);
    chk("t5_int_win", int_out, 1);
    chk("t5_idx", wr_buf_index, 6);
    chk("t5_done", done, 1);
    cyc(1);
    int_clr = 1'b0;
    cyc(1);
    int_clr = 1'b1;
    cyc(1);
    int_clr = 1'b0;
    @(negedge axim_clk);
    chk("t5_int_clr2", int_out, 0);

    // Overflow flag is sticky until go rises, and a same-cycle pulse wins
    data_len = 100;
    fifo_ovf = 1'b1;
    cyc(1);
    fifo_ovf = 1'b0;
    @(negedge axim_clk);
    chk("t5_ovf_set", fifo_overflow, 1);
    cyc(5);
    chk("t5_ovf_hold", fifo_overflow, 1);
    go = 1'b1;
    cyc(1);
    go = 1'b0;
    @(negedge axim_clk);
    chk("t5_ovf_clr", fifo_overflow, 0);
    cyc(1);
    go = 1'b1;
    fifo_ovf = 1'b1;
    cyc(1);
    go = 1'b0;
    fifo_ovf = 1'b0;
    @(negedge axim_clk);
    chk("t5_ovf_win", fifo_overflow, 1);

    // Reset in the middle of a burst, then restart
    aw_cnt = 0; b_cnt = 0;
    data_len = 512;
    wr_addr_0 = 32'h1000_0000;
    push_words(16);
    expect_bursts(32'h1000_0000, 1);
    cyc(1);
    go = 1'b1;
    wait_cnt("t6_beat7", 2, 7);
    @(posedge axim_clk);
    #3;
    do_reset();
    data_len = 128;
    push_words(16);
    expect_bursts(32'h1000_0000, 1);
    cyc(1);
    go = 1'b1;
    wait_cnt("t6_aw", 0, 1);
    cyc(1);
    go = 1'b0;
    wait_cnt("t6_b", 1, 1);
    cyc(3);
    chk("t6_wcount", write_count, 128);
    chk("t6_done", done, 1);
    chk("t6_idx", wr_buf_index, 1);
    chk("t6_aw_left", exp_aw.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/adc_axim_buf_writer.md
Name: adc_axim_buf_writer

Overview:
- AXI4 write-master stage in the axim clock domain, directly downstream of the ADC register block.
- Consumes the control words from that block: go, int_clr, data_len, wr_addr_0 and wr_addr_1.
- Drains ADC samples from a first-word-fall-through (FWFT) sample FIFO into two ping-pong DDR buffers using fixed-length INCR bursts.
- Returns status to the register block: done, int_out, fifo_overflow, wr_buf_index and write_count.

Parameters:
DATA_WIDTH, 64, AXI data and FIFO word width in bits (32 or 64).
BURST_LEN, 16, beats per burst (2..256); burst bytes BB = BURST_LEN*DATA_WIDTH/8.
CNT_WIDTH, 10, width of fifo_rd_count.

Ports:
axim_clk  in  1  sole clock
axim_rstn  in  1  reset, asynchronous assert, active-low
go  in  1  run enable, level
int_clr  in  1  interrupt clear, rising-edge active
data_len  in  32  bytes per buffer
wr_addr_0  in  32  buffer 0 base byte address
wr_addr_1  in  32  buffer 1 base byte address
fifo_rd_data  in  DATA_WIDTH  FWFT head word
fifo_rd_count  in  CNT_WIDTH  words available
fifo_ovf  in  1  FIFO write-side overflow pulse
fifo_rd_en  out  1  pop head word
m_axi_awaddr  out  32  burst address
m_axi_awlen  out  8  constant BURST_LEN-1
m_axi_awsize  out  3  constant log2(DATA_WIDTH/8)
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid  out  1  address valid
m_axi_awready  in  1  address ready
m_axi_wdata  out  DATA_WIDTH  equals fifo_rd_data
m_axi_wstrb  out  DATA_WIDTH/8  all ones
m_axi_wlast  out  1  last beat of burst
m_axi_wvalid  out  1  data valid
m_axi_wready  in  1  data ready
m_axi_bresp  in  2  write response (ignored for counting)
m_axi_bvalid  in  1  response valid
m_axi_bready  out  1  response ready
done  out  1  idle after a completed buffer
int_out  out  1  sticky buffer-complete interrupt
fifo_overflow  out  1  sticky overflow flag
wr_buf_index  out  4  completed-buffer count mod 16
write_count  out  32  bytes acknowledged in the current buffer

Behaviour:
- Reset (axim_rstn low, asynchronous):
  - All outputs 0 immediately, including all AXI valids, bready, fifo_rd_en and all status outputs.
  - State returns to IDLE; the go and int_clr edge registers are cleared.
- Edge detect:
  - go_rise = go & ~go_d.
  - int_clr_rise is derived from int_clr the same way.
- States and transitions:
  - IDLE: on go_rise, clear done, fifo_overflow and write_count. Then:
    - if data_len < BB, stay in IDLE (no writes, done stays 0);
    - otherwise latch the buffer parameters and go to WAIT.
  - Latched buffer parameters:
    - nbursts = data_len / BB; remainder bytes are dropped.
    - base = wr_addr_0 when cur_buf = 0, else wr_addr_1, with the low log2(BB) bits forced to 0.
    - burst counter cleared.
  - WAIT: when fifo_rd_count >= BURST_LEN, go to AW.
  - AW:
    - awvalid = 1 and awaddr = base + burst_idx*BB.
    - awaddr is held stable until awready; on awvalid & awready, go to W.
  - W:
    - wvalid = 1; fifo_rd_en = wvalid & wready.
    - The beat counter counts handshakes; wlast = 1 when beat = BURST_LEN-1.
    - On the last handshake, go to B.
  - B:
    - bready = 1.
    - On bvalid: write_count += BB; burst_idx += 1; go to NEXT.
  - NEXT:
    - If burst_idx < nbursts: go to WAIT when go = 1, else to IDLE (a burst is never aborted once AW has been issued).
    - If the buffer is complete:
      - int_out <= 1;
      - wr_buf_index += 1 (wraps 15 -> 0);
      - cur_buf toggles;
      - if go = 1, relatch parameters for the new buffer (write_count <= 0) and go to WAIT;
      - otherwise done <= 1 and go to IDLE.
- Stop with go = 0:
  - The current burst always finishes through B.
  - If the stop lands mid-buffer, the state returns to IDLE with done = 0.
  - write_count holds the partial byte count.
- int_out:
  - int_clr_rise clears it.
  - A completion in the same cycle as int_clr_rise wins, so int_out stays 1.
- fifo_overflow:
  - Set by any fifo_ovf pulse; cleared only by go_rise.
  - fifo_ovf in the same cycle as go_rise: the flag ends at 1.
- cur_buf: reset value 0; it is not reset by go, so ping-pong order continues across runs.
- AXI rules:
  - Valids do not depend combinationally on readies.
  - At most one outstanding burst.
  - A nonzero bresp is still counted.

Test Plan:
- Single buffer:
  - Stimulus: DATA_WIDTH = 64, BURST_LEN = 16 (BB = 128); wr_addr_0 = 0x1000_0000, data_len = 512; FIFO pre-filled with 64 words; pulse go high then low after 4 bursts.
  - Response: 4 AW beats at 0x1000_0000, 0x1000_0080, 0x1000_0100, 0x1000_0180, each with awlen = 15 and awsize = 3; 64 W beats carrying the FIFO data in order; wlast on beats 16/32/48/64; write_count = 512; done = 1; int_out = 1; wr_buf_index = 1.
- Ping-pong:
  - Stimulus: go held high; wr_addr_1 = 0x2000_0000; data_len = 256.
  - Response: bursts at 0x1000_0000, 0x1000_0080, then 0x2000_0000, 0x2000_0080, then back to 0x1000_0000; wr_buf_index steps 1, 2, 3; write_count returns to 0 at each buffer start.
- Backpressure:
  - Stimulus: awready delayed 5 cycles; wready toggled every cycle; FIFO count 15 for 20 cycles before rising to 16.
  - Response: no awvalid while count < 16; awaddr stable while waiting for awready; fifo_rd_en high only on W handshakes; exactly 16 pops per burst.
- Edge cases:
  - data_len = 300 → 2 bursts; write_count = 256.
  - data_len = 100 → no AXI traffic, done stays 0.
  - wr_addr_0 = 0x1000_0044 → first awaddr = 0x1000_0000.
- Interrupt and overflow:
  - int_clr rising in the same cycle as a completion → int_out stays 1.
  - fifo_ovf pulse → fifo_overflow stays 1 until the next go rise.
- Reset mid-burst:
  - Stimulus: axim_rstn low during W beat 7.
  - Response: wvalid, int_out, done, write_count and wr_buf_index go to 0 immediately; after release, go_rise restarts writing at wr_addr_0.
